fft_collector: RTL

FFT_COLLECTOR -- requirements
Module: fft_collector

---
 rtl/fft_collector.sv | 90 +++++++++
 1 files changed

// File: rtl/fft_collector.sv
// Double-buffered frame collector between the FIR and FFT stages. Samples fill
// one bank while the other is presented to the FFT, which takes a whole frame per handshake.
module fft_collector #(
    parameter int N = 16,
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] fir_d,
    input  logic                fir_valid,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [N*W-1:0]      out_data,
    output logic [7:0]          frame_cnt,
    output logic                overflow,
    output logic [1:0]          state_dbg
);
    // Handshake: a frame moves downstream on every rising edge where out_valid
    // and out_ready are both high; out_valid/out_data hold steady until then.
    // fir_valid has no back-pressure: a sample offered while both banks are full is lost.

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Encoding equals the number of full banks.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            wr_sel, rd_sel;
    logic [IW-1:0]   wr_idx;
    logic [W-1:0]    bank [2][N];
    logic            accept, frame_done, handshake;

    assign accept     = fir_valid && (state != S_TWO);
    assign frame_done = accept && (wr_idx == IW'(N - 1));
    assign handshake  = out_valid && out_ready;
    assign out_valid  = (state != S_EMPTY);
    assign state_dbg  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (frame_done) state_nxt = S_ONE;
            S_ONE: begin
                if (frame_done && !handshake)      state_nxt = S_TWO;
                else if (handshake && !frame_done) state_nxt = S_EMPTY;
            end
            S_TWO:   if (handshake) state_nxt = S_ONE;
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_EMPTY;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_idx    <= '0;
            frame_cnt <= 8'd0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                wr_idx <= frame_done ? '0 : wr_idx + 1'b1;
            if (frame_done)
                wr_sel <= ~wr_sel;
            if (handshake) begin
                rd_sel    <= ~rd_sel;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (fir_valid && (state == S_TWO))
                overflow <= 1'b1;
        end
    end

    // Bank storage carries no reset; contents are meaningless until a frame completes.
    always_ff @(posedge clk) begin
        if (rst && accept)
            bank[wr_sel][wr_idx] <= fir_d;
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < N; k++)
            out_data[k*W +: W] = bank[rd_sel][k];
    end
endmodule
